// File: rtl/rv32_prefetch_buffer.sv
// RV32 instruction prefetch buffer: keeps up to MAX_OUTSTANDING fetches in
// flight and queues returned {pc, instr} pairs for the decode stage.
module rv32_prefetch_buffer #(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        instr_ready_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

    logic [31:0]   fetch_pc;
    logic [31:0]   fifo_pc    [DEPTH];
    logic [31:0]   fifo_instr [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] fifo_cnt;
    logic [OW-1:0] outstanding;
    logic [OW-1:0] discard;
    logic [31:0]   pcq [MAX_OUTSTANDING];
    logic [QW-1:0] pcq_rd;
    logic [QW-1:0] pcq_wr;

    logic        rsp;
    logic        drop;
    logic        push;
    logic        pop;
    logic        accept;
    logic [31:0] occ;
    logic        unused_lsb;

    assign unused_lsb = ^redirect_pc_i[1:0];

    function automatic logic [QW-1:0] qinc(input logic [QW-1:0] p);
        return (32'(p) == 32'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // A response with nothing outstanding is a protocol error and is ignored.
    always_comb begin
        rsp  = mem_rvalid_i && (outstanding != '0);
        drop = rsp && (discard != '0);
        push = rsp && (discard == '0) && !redirect_i && !rst_i;
        occ  = 32'(fifo_cnt) + 32'(outstanding) - 32'(discard);
        mem_req_o = !rst_i && !redirect_i &&
                    (32'(outstanding) < 32'(MAX_OUTSTANDING)) &&
                    (occ < 32'(DEPTH));
        accept = mem_req_o && mem_gnt_i;
        instr_valid_o = !rst_i && (fifo_cnt != '0);
        pop = instr_valid_o && instr_ready_i && !redirect_i;
    end

    assign mem_addr_o = fetch_pc;
    assign instr_o    = instr_valid_o ? fifo_instr[rd_ptr] : '0;
    assign pc_o       = instr_valid_o ? fifo_pc[rd_ptr] : '0;
    assign pc_next_o  = instr_valid_o ? fifo_pc[rd_ptr] + 32'd4 : '0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            fetch_pc    <= {RESET_PC[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= '0;
            discard     <= '0;
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else if (redirect_i) begin
            // Everything still in flight belongs to the wrong path.
            fetch_pc    <= {redirect_pc_i[31:2], 2'b00};
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            fifo_cnt    <= '0;
            outstanding <= outstanding - OW'(rsp);
            discard     <= outstanding - OW'(rsp);
            pcq_rd      <= '0;
            pcq_wr      <= '0;
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + 32'd4;
                pcq_wr   <= qinc(pcq_wr);
            end
            outstanding <= outstanding + OW'(accept) - OW'(rsp);
            if (drop) begin
                discard <= discard - 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
                pcq_rd <= qinc(pcq_rd);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            pcq[pcq_wr] <= fetch_pc;
        end
        if (push) begin
            fifo_pc[wr_ptr]    <= pcq[pcq_rd];
            fifo_instr[wr_ptr] <= mem_rdata_i;
        end
    end

endmodule

// File: doc/rv32_prefetch_buffer.md
RV32_PREFETCH_BUFFER -- requirements
Module: rv32_prefetch_buffer

Interface
REQ-001 SHALL provide parameter DEPTH, default 4: instruction FIFO entries (power of two, ≥2).
REQ-002 SHALL provide parameter MAX_OUTSTANDING, default 2: maximum granted but unanswered memory requests.
REQ-003 SHALL provide parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as follows:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  synchronous, active-high reset.
- redirect_i  in  1  core redirect (branch/jump taken).
- redirect_pc_i  in  32  redirect target.
- instr_ready_i  in  1  core consumes the head entry.
- instr_valid_o  out  1  head entry valid.
- instr_o  out  32  head instruction.
- pc_o  out  32  head instruction address.
- pc_next_o  out  32  pc_o+4.
- mem_req_o  out  1  instruction-memory request.
- mem_addr_o  out  32  request address, word aligned.
- mem_gnt_i  in  1  request accepted this cycle.
- mem_rvalid_i  in  1  in-order read response valid.
- mem_rdata_i  in  32  response data.

Function
REQ-005 SHALL keep fetch_pc, a DEPTH-entry FIFO of {pc, instr}, an outstanding counter and a discard counter.
REQ-006 mem_addr_o SHALL equal fetch_pc; fetch_pc[1:0] SHALL always be 2'b00.
REQ-007 mem_req_o SHALL be 1 iff: not in reset, redirect_i=0, outstanding<MAX_OUTSTANDING, and FIFO count+outstanding−discard<DEPTH.
REQ-008 A request SHALL be accepted only when mem_req_o=1 and mem_gnt_i=1. On acceptance: outstanding+1, fetch_pc+4 (32-bit wrap, 32'hFFFF_FFFC→0), and the request's pc enters an internal in-order pc queue.
REQ-009 For mem_rvalid_i=1, outstanding SHALL decrement. If discard>0, discard SHALL decrement and the data SHALL be dropped. Otherwise {queued pc, mem_rdata_i} SHALL be pushed to the FIFO.
REQ-010 A response pushed in cycle N SHALL appear at the head no earlier than cycle N+1. There is no combinational bypass.
REQ-011 instr_valid_o SHALL be 1 iff the FIFO is non-empty. instr_o, pc_o and pc_next_o SHALL come from the head entry.
REQ-012 Pop SHALL occur when instr_valid_o=1 and instr_ready_i=1. Push and pop in the same cycle SHALL leave the count unchanged.
REQ-013 The FIFO SHALL never overflow (guaranteed by REQ-007). Popping an empty FIFO SHALL have no effect.
REQ-014 On redirect_i=1, in order:
- FIFO cleared.
- fetch_pc = {redirect_pc_i[31:2],2'b00}.
- Same-cycle mem_rvalid_i dropped.
- discard = outstanding − mem_rvalid_i.
- outstanding = outstanding − mem_rvalid_i.
- pc queue flushed.
- Same-cycle pop ignored.
REQ-015 A redirect while discard>0 SHALL recompute discard per REQ-014, with no double counting.
REQ-016 The first non-discarded response after a redirect SHALL carry pc = redirect target.
REQ-017 Outstanding SHALL saturate neither up nor down. mem_rvalid_i with outstanding=0 is a protocol error: ignored, no state change.

Reset
REQ-018 While rst_i=1, mem_req_o and instr_valid_o SHALL be 0, with FIFO, outstanding, discard and pc queue cleared and fetch_pc=RESET_PC.
REQ-019 In the first cycle after rst_i deasserts, mem_req_o SHALL be 1 with mem_addr_o=RESET_PC.
REQ-020 Reset mid-operation SHALL abandon all in-flight requests; responses arriving after reset SHALL be ignored per REQ-017.
REQ-021 instr_o, pc_o and pc_next_o SHALL read 0 while the FIFO is empty.

Verification
REQ-022 Reset release, gnt=1, 1-cycle response latency, ready=1 -> sequential pcs 0x0,0x4,0x8… on pc_o; first instr_valid_o two cycles after the first grant.
REQ-023 ready=0, gnt=1, DEPTH=4 -> exactly 4 requests issued, then mem_req_o=0; instr_valid_o stays 1 with pc_o=0x0; one pop then frees one request.
REQ-024 2 outstanding (pcs 0x10, 0x14), redirect to 0x203 -> next mem_addr_o=0x200; both late responses dropped; first valid head pc_o=0x200.
REQ-025 Redirect in the same cycle as mem_rvalid_i and a pop -> FIFO empty next cycle, discard=outstanding−1, no stale instruction ever valid.
REQ-026 fetch_pc=0xFFFF_FFFC, grant -> next mem_addr_o=0x0000_0000; pc_next_o for that head = 0x0.
REQ-027 rst_i asserted with 2 outstanding, later rvalid pulses -> ignored; first post-reset head pc_o=RESET_PC.
